uart_rx_8n1_fifo: RTL and testbench

//  Receive half of the SoC console UART: 8N1 serial receiver with 16x oversampling and a small byte FIFO.
//  It runs directly on the 12 MHz core clock and uses a clock-enable tick, not a derived clock.
//  Its ready/valid byte output is read by the data-bus responder at 0x9000_0004.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/uart_rx_8n1_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_rx_8n1_fifo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the console UART register addresses on the data bus.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    localparam logic [31:0] UART_TX_ADDR   = 32'h9000_0000;
    localparam logic [31:0] UART_RX_ADDR   = 32'h9000_0004;
    localparam logic [31:0] UART_STAT_ADDR = 32'h9000_0008;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; head entry is read straight
// from the storage registers so dout holds steady until a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_8n1_fifo.sv
// 8N1 console UART receiver: 16x oversampled on the core clock via a tick
// enable, with received bytes queued in a small ready/valid FIFO.
module uart_rx_8n1_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    rx_state_t        state;
    rx_state_t        next_state;
    logic [1:0]       sync_q;
    logic             rx_s;
    logic             rx_prev;
    logic             start_edge;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             sample_now;
    logic             push_byte;
    logic             stop_bad;
    logic             fifo_full;
    logic             fifo_empty;

    assign rx_s       = sync_q[1];
    assign start_edge = (state == IDLE) && rx_prev && !rx_s;
    assign tick       = (div_cnt == DIV_W'(DIV - 1));
    assign sample_now = tick && ((state == START) ? (tick_cnt == 4'(MID_SAMPLE - 1))
                                                  : (tick_cnt == 4'(OVERSAMPLE - 1)));
    assign busy       = (state != IDLE);
    assign rx_valid   = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            rx_prev <= rx_s;
        end
    end

    // Restarting the divider on the start edge centres every later sample in its bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (start_edge || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (start_edge) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (tick) begin
                tick_cnt <= sample_now ? 4'd0 : tick_cnt + 4'd1;
            end
            if (state == DATA && sample_now) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        push_byte  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE:  if (start_edge) next_state = START;
            START: if (sample_now) next_state = rx_s ? IDLE : DATA;
            DATA:  if (sample_now && bit_cnt == 3'd7) next_state = STOP;
            STOP: begin
                // Returning to IDLE on the stop sample leaves half a bit to catch the next start edge.
                if (sample_now) begin
                    if (rx_s) begin
                        push_byte  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        next_state = BREAK;
                    end
                end
            end
            BREAK: if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= push_byte && fifo_full && !rx_ready;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_byte),
        .din   (shift_reg),
        .pop   (rx_ready),
        .dout  (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_8n1_fifo.sv
// Scoreboard bench for uart_rx_8n1_fifo, run at a reduced line rate (64 clk per bit)
// so the whole sequence stays short.
module tb_uart_rx_8n1_fifo;

    localparam int CLK_HZ = 640000;
    localparam int BAUD   = 10000;
    localparam int DEPTH  = 4;
    localparam int BIT    = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic [7:0] exp_q[$];
    int         checks  = 0;
    int         errors  = 0;
    int         fe_cnt  = 0;
    int         ov_cnt  = 0;
    int         ov_exp  = 0;
    int         fe_exp  = 0;
    int         pop_cnt = 0;

    uart_rx_8n1_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (rx_i),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitBits(input int n);
        repeat (n * BIT) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame; the reference FIFO decides keep/drop as the stop bit begins.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        rx_i = 1'b0;
        waitBits(1);
        for (int i = 0; i < 8; i++) begin
            rx_i = data[i];
            waitBits(1);
        end
        if (stop_bit) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(data);
            else ov_exp++;
        end else begin
            fe_exp++;
        end
        rx_i = stop_bit;
        waitBits(1);
    endtask

    task automatic drain(input string name);
        rx_ready = 1'b1;
        for (int i = 0; i < 20 * DEPTH && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput({name, "_drained"}, exp_q.size(), 0);
        checkOutput({name, "_valid_low"}, {31'd0, rx_valid}, 0);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_rx_valid"}, {31'd0, rx_valid}, 0);
        checkOutput({name, "_rx_data"}, {24'd0, rx_data}, 0);
        checkOutput({name, "_frame_err"}, {31'd0, frame_err}, 0);
        checkOutput({name, "_overrun"}, {31'd0, overrun}, 0);
        checkOutput({name, "_busy"}, {31'd0, busy}, 0);
    endtask

    // Monitor: pops the scoreboard on every accepted byte and tallies error pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_err) fe_cnt++;
                if (overrun) ov_cnt++;
                if (frame_err || overrun) begin
                    checkOutput("err_exclusive", {31'd0, frame_err & overrun}, 0);
                end
                if (rx_valid && rx_ready) begin
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_pop: got byte %0h expected none", rx_data);
                    end else begin
                        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        int fe_base;
        int pops_base;
        int n;

        rst      = 1'b1;
        rx_i     = 1'b1;
        rx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] single byte with consumer ready");
        rx_ready = 1'b1;
        applyStimulus(8'h55, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t1_delivered", exp_q.size(), 0);
        checkOutput("t1_frame_err", fe_cnt, 0);
        checkOutput("t1_overrun", ov_cnt, 0);

        $display("[TB] back-to-back frames held in the FIFO");
        rx_ready = 1'b0;
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t2_valid", {31'd0, rx_valid}, 1);
        checkOutput("t2_head", {24'd0, rx_data}, 32'hA5);
        drain("t2");

        $display("[TB] overflow with five bytes");
        rx_ready = 1'b0;
        for (int b = 1; b <= 5; b++) applyStimulus(8'(b), 1'b1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t3_overrun", ov_cnt, ov_exp);
        checkOutput("t3_kept", exp_q.size(), DEPTH);
        drain("t3");

        $display("[TB] framing error then held-low line");
        rx_ready = 1'b1;
        fe_base  = fe_cnt;
        applyStimulus(8'h81, 1'b0);
        waitBits(30);
        checkOutput("t4_busy_low", {31'd0, busy}, 1);
        checkOutput("t4_one_frame_err", fe_cnt - fe_base, 1);
        rx_i = 1'b1;
        waitBits(1);
        checkOutput("t4_idle_after_rise", {31'd0, busy}, 0);
        applyStimulus(8'h42, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t4_recovered", exp_q.size(), 0);

        $display("[TB] short glitch on idle line");
        fe_base = fe_cnt;
        rx_i = 1'b0;
        repeat (BIT / 3) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_busy_during", {31'd0, busy}, 1);
        repeat (BIT) @(posedge clk);
        #1;
        checkOutput("t5_busy_after", {31'd0, busy}, 0);
        checkOutput("t5_no_frame_err", fe_cnt - fe_base, 0);
        checkOutput("t5_no_push", {31'd0, rx_valid}, 0);

        $display("[TB] reset in the middle of a frame");
        rx_ready = 1'b1;
        rx_i = 1'b0;
        waitBits(1);
        for (int i = 0; i < 4; i++) begin
            rx_i = (i == 0 || i == 3);
            waitBits(1);
        end
        rst  = 1'b1;
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("t6_in_reset");
        rst = 1'b0;
        waitBits(2);
        pops_base = pop_cnt;
        applyStimulus(8'h99, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t6_one_byte", pop_cnt - pops_base, 1);

        $display("[TB] randomized bursts");
        for (int r = 0; r < 8; r++) begin
            rx_ready = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) applyStimulus(8'($urandom), 1'b1);
            drain("rand");
            repeat ($urandom_range(0, BIT)) @(posedge clk);
            #1;
        end

        checkOutput("total_frame_err", fe_cnt, fe_exp);
        checkOutput("total_overrun", ov_cnt, ov_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
